apu_pingpong_buf: RTL and testbench
===================================

Name: apu_pingpong_buf

Overview:
- Double-buffered (ping-pong) event buffer that chains two APU stages.
- Its write side accepts the memory-write interface an APU wrapper drives out: wr_en/wr_addr/wr_data plus a wr_EvTID_done pulse.
- Its read side answers the memory-read interface an upstream adaptor initiates: rd_en/rd_addr to rd_data, rd_EvTID_ready and rd_EvTID_done.
- Stage N can therefore fill one bank while stage N+1 drains the other.

Parameters:
ADDR_WIDTH, 10, word address width per bank; bank depth is 2**ADDR_WIDTH words of 128 bits.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe from producer APU
wr_addr  in  ADDR_WIDTH  write word address
wr_data  in  128  write data
wr_EvTID_done  in  1  one-cycle pulse: producer event complete, close current write bank
rd_en  in  1  read strobe from consumer adaptor
rd_addr  in  ADDR_WIDTH  read word address
rd_data  out  128  read data, 1-cycle latency
rd_EvTID_ready  out  1  level: a complete event is available to read
rd_EvTID_done  in  1  one-cycle pulse: consumer finished, release current read bank
rd_words  out  ADDR_WIDTH+1  word count of the event in the read bank (highest written address + 1)
ovf_err  out  1  sticky: write or done arrived while both banks were FULL
urun_err  out  1  sticky: rd_en while rd_EvTID_ready low

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port named reset.
- Reset values:
  - rd_data=0, rd_EvTID_ready=0, rd_words=0, ovf_err=0, urun_err=0.
  - Write bank pointer wb=0, read bank pointer rb=0.
  - Both bank states EMPTY; per-bank word counts 0.
  - RAM contents are not cleared.
- Bank state per bank (2 bits): EMPTY, FILLING, FULL.
  - EMPTY->FILLING on first wr_en into that bank.
  - EMPTY or FILLING->FULL on wr_EvTID_done, even with zero words; wb then toggles.
  - FULL->EMPTY on rd_EvTID_done while it is the read bank; rb then toggles and the word count clears.
- Write path:
  - If bank[wb] is not FULL, wr_en writes wr_data at bank[wb][wr_addr].
  - Word count for that bank is updated to max(count, wr_addr+1).
  - If bank[wb] is FULL (both banks full), the write is dropped and ovf_err sets.
  - wr_EvTID_done while bank[wb] is FULL is ignored and sets ovf_err.
  - wr_en and wr_EvTID_done in the same cycle: the write lands in the closing bank and counts toward its words.
- Ready timing:
  - rd_EvTID_ready is registered and equals (bank[rb]==FULL).
  - wr_EvTID_done at cycle t into bank rb gives rd_EvTID_ready=1 at t+1.
  - rd_words is valid whenever rd_EvTID_ready=1 and updates in the same cycle as ready.
- Read path:
  - rd_en at cycle t with ready=1: rd_data = bank[rb][rd_addr] at t+1.
  - The bank select is captured with the address, so rd_en coincident with rd_EvTID_done reads the old bank.
  - rd_en with ready=0: no RAM access, rd_data=0 at t+1, urun_err sets.
  - rd_data holds its last value when rd_en=0.
- Release:
  - rd_EvTID_done at cycle t: rd_EvTID_ready=0 at t+1, unless the other bank is FULL.
  - In that case ready stays 1 at t+1 and rd_words shows the new bank's count at t+1.
  - rd_EvTID_done with ready=0 is ignored.
- Simultaneous events:
  - wr_EvTID_done on bank[wb] and rd_EvTID_done on bank[rb] with wb!=rb: both transitions apply in the same cycle.
  - When wb==rb only one of the two is legal for the bank's state; the other is handled by the rules above.
- Reset mid-event: all state returns to reset values at the next edge; partial events are discarded.
- No same-bank read/write collision is possible, because reads require FULL and writes are blocked on FULL.

Decomposition:
- Package apu_buf_pkg:
  - DATA_WIDTH=128, NUM_BANKS=2.
  - typedef enum logic [1:0] bank_state_t {EMPTY, FILLING, FULL}.
  - typedef logic [DATA_WIDTH-1:0] word_t.
- Sub-module apu_buf_bank (ADDR_WIDTH):
  - 1R1W synchronous RAM with registered read.
  - Instantiated twice.
- Top level holds the bank FSMs, pointers, word counters and error flags.

Test Plan:
- Basic event: reset; write addr 0..3 = 0xA0..0xA3; wr_EvTID_done at t -> ready=1 at t+1, rd_words=4. Read addr 2 -> rd_data=0xA2 one cycle later.
- Ping-pong: event A (8 words, bank0) done; write event B (5 words, bank1) while reading A; rd_EvTID_done -> ready stays 1, rd_words=5, read addr 0 returns B[0].
- Overflow: fill both banks (A, B), then wr_en addr 0 = 0xFF and wr_EvTID_done -> ovf_err=1. After releasing A, bank0 contents are unchanged and ready stays 1 for B.
- Underrun: rd_en addr 3 with ready=0 -> rd_data=0 next cycle, urun_err=1, stays 1 until reset.
- Coincident events:
  - wr_EvTID_done (bank1, 6 words) in the same cycle as rd_EvTID_done (bank0) -> next cycle ready=1, rd_words=6, both bank states updated.
  - Separately, wr_en+wr_EvTID_done on the same cycle at addr 9 -> rd_words=10.
- Reset mid-operation: reset asserted during bank0 FILLING with bank1 FULL -> next cycle ready=0, rd_words=0, flags 0. A subsequent 1-word event reads back correctly from bank0.

Source files
------------

// File: rtl/apu_buf_pkg.sv
// Shared types for the APU ping-pong event buffer: word type and per-bank
// occupancy state.
package apu_buf_pkg;

   localparam int DATA_WIDTH = 128;
   localparam int NUM_BANKS  = 2;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } bank_state_t;

   typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/apu_buf_bank.sv
// One event bank: 1R1W synchronous RAM with a registered read port.
// Contents are never cleared; the read register holds when re is low.
module apu_buf_bank
   import apu_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  word_t                 wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output word_t                 rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   word_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/apu_pingpong_buf.sv
// Ping-pong event buffer between two APU stages: the producer fills bank[wb]
// while the consumer drains bank[rb]; a bank is readable only once FULL.
module apu_pingpong_buf
   import apu_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_EvTID_done,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_EvTID_ready,
   input  logic                  rd_EvTID_done,
   output logic [ADDR_WIDTH:0]   rd_words,
   output logic                  ovf_err,
   output logic                  urun_err
);

   localparam int CNT_W = ADDR_WIDTH + 1;

   bank_state_t      st_q   [NUM_BANKS];
   bank_state_t      st_n   [NUM_BANKS];
   logic [CNT_W-1:0] cnt_q  [NUM_BANKS];
   logic [CNT_W-1:0] cnt_n  [NUM_BANKS];
   logic             wb_q, wb_n;
   logic             rb_q, rb_n;
   logic             ready_q, ready_n;
   logic [CNT_W-1:0] words_q, words_n;
   logic             ovf_q, ovf_n;
   logic             urun_q, urun_n;
   logic             wr_open;
   logic             rd_open;

   logic [NUM_BANKS-1:0] bank_we;
   logic [NUM_BANKS-1:0] bank_re;
   word_t                bank_rdata [NUM_BANKS];

   logic rd_sel_p1;
   logic rd_zero_p1;

   // Word count is the highest written address + 1, so it never shrinks mid-event.
   function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                   input logic [ADDR_WIDTH-1:0] addr);
      logic [CNT_W-1:0] span;
      span = {1'b0, addr} + CNT_W'(1);
      return (span > cur) ? span : cur;
   endfunction

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         st_n[b]  = st_q[b];
         cnt_n[b] = cnt_q[b];
      end
      wb_n    = wb_q;
      rb_n    = rb_q;
      ovf_n   = ovf_q;
      urun_n  = urun_q;
      bank_we = '0;
      bank_re = '0;
      wr_open = (st_q[wb_q] != FULL);
      rd_open = (st_q[rb_q] == FULL);

      // Producer side: a FULL write bank means both banks are occupied.
      if (wr_en) begin
         if (wr_open) begin
            bank_we[wb_q] = 1'b1;
            cnt_n[wb_q]   = next_count(cnt_q[wb_q], wr_addr);
            if (st_q[wb_q] == EMPTY) begin
               st_n[wb_q] = FILLING;
            end
         end else begin
            ovf_n = 1'b1;
         end
      end

      if (wr_EvTID_done) begin
         if (wr_open) begin
            st_n[wb_q] = FULL;
            wb_n       = ~wb_q;
         end else begin
            ovf_n = 1'b1;
         end
      end

      // Consumer side: when wb==rb the bank cannot be both open and FULL,
      // so this never fights the producer updates above.
      if (rd_EvTID_done && rd_open) begin
         st_n[rb_q]  = EMPTY;
         cnt_n[rb_q] = '0;
         rb_n        = ~rb_q;
      end

      if (rd_en) begin
         if (ready_q) begin
            bank_re[rb_q] = 1'b1;
         end else begin
            urun_n = 1'b1;
         end
      end

      ready_n = (st_n[rb_n] == FULL);
      words_n = ready_n ? cnt_n[rb_n] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            st_q[b]  <= EMPTY;
            cnt_q[b] <= '0;
         end
         wb_q       <= 1'b0;
         rb_q       <= 1'b0;
         ready_q    <= 1'b0;
         words_q    <= '0;
         ovf_q      <= 1'b0;
         urun_q     <= 1'b0;
         rd_sel_p1  <= 1'b0;
         rd_zero_p1 <= 1'b1;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            st_q[b]  <= st_n[b];
            cnt_q[b] <= cnt_n[b];
         end
         wb_q    <= wb_n;
         rb_q    <= rb_n;
         ready_q <= ready_n;
         words_q <= words_n;
         ovf_q   <= ovf_n;
         urun_q  <= urun_n;
         // Read stage p0 -> p1: bank select travels with the address.
         if (rd_en) begin
            rd_sel_p1  <= rb_q;
            rd_zero_p1 <= ~ready_q;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      apu_buf_bank #(
         .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we[b]),
         .waddr (wr_addr),
         .wdata (wr_data),
         .re    (bank_re[b]),
         .raddr (rd_addr),
         .rdata (bank_rdata[b])
      );
   end

   // Read stage p1: bank RAM registers hold between reads, so the mux holds too.
   assign rd_data        = rd_zero_p1 ? '0 : bank_rdata[rd_sel_p1];
   assign rd_EvTID_ready = ready_q;
   assign rd_words       = words_q;
   assign ovf_err        = ovf_q;
   assign urun_err       = urun_q;

endmodule

// File: tb/tb_apu_pingpong_buf.sv
// Directed + randomized bench for apu_pingpong_buf against an event-queue
// reference model (completed events in order, plus one event being filled).
module tb_apu_pingpong_buf;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [127:0]  wr_data = '0;
   logic          wr_EvTID_done = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [127:0]  rd_data;
   logic          rd_EvTID_ready;
   logic          rd_EvTID_done = 1'b0;
   logic [AW:0]   rd_words;
   logic          ovf_err;
   logic          urun_err;

   always #5 clk = ~clk;

   apu_pingpong_buf #(.ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_EvTID_done  (wr_EvTID_done),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .rd_EvTID_ready (rd_EvTID_ready),
      .rd_EvTID_done  (rd_EvTID_done),
      .rd_words       (rd_words),
      .ovf_err        (ovf_err),
      .urun_err       (urun_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   string cur_tag = "init";

   // Reference model: completed events queue (capacity two), one filling event.
   longint       ev_q[$];
   int           ev_cnt[longint];
   logic [127:0] m_mem[longint];
   longint       fill_id = 0;
   int           fill_cnt = 0;
   logic [127:0] exp_rd = '0;
   bit           rd_known = 1'b1;
   logic         exp_ovf = 1'b0;
   logic         exp_urun = 1'b0;

   function automatic longint key(input longint id, input int a);
      return id * 64'd4096 + longint'(a);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string what, input logic [127:0] obs, input logic [127:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, what, obs, expv);
      end
   endtask

   task automatic step(input bit rst, input bit we, input int wa, input logic [127:0] wd,
                       input bit wdn, input bit re, input int ra, input bit rdn);
      int  sz;
      bit  rdy;
      int  exp_words;
      reset         = rst;
      wr_en         = we;
      wr_addr       = wa[AW-1:0];
      wr_data       = wd;
      wr_EvTID_done = wdn;
      rd_en         = re;
      rd_addr       = ra[AW-1:0];
      rd_EvTID_done = rdn;
      if (rst) begin
         ev_q.delete();
         fill_id++;
         fill_cnt = 0;
         exp_rd   = '0;
         rd_known = 1'b1;
         exp_ovf  = 1'b0;
         exp_urun = 1'b0;
      end else begin
         sz  = ev_q.size();
         rdy = (sz > 0);
         if (re) begin
            if (rdy) begin
               if (m_mem.exists(key(ev_q[0], ra))) begin
                  exp_rd   = m_mem[key(ev_q[0], ra)];
                  rd_known = 1'b1;
               end else begin
                  rd_known = 1'b0;
               end
            end else begin
               exp_rd   = '0;
               rd_known = 1'b1;
               exp_urun = 1'b1;
            end
         end
         if (we) begin
            if (sz < 2) begin
               m_mem[key(fill_id, wa)] = wd;
               if (wa + 1 > fill_cnt) fill_cnt = wa + 1;
            end else begin
               exp_ovf = 1'b1;
            end
         end
         if (wdn) begin
            if (sz < 2) begin
               ev_q.push_back(fill_id);
               ev_cnt[fill_id] = fill_cnt;
               fill_id++;
               fill_cnt = 0;
            end else begin
               exp_ovf = 1'b1;
            end
         end
         if (rdn && rdy) void'(ev_q.pop_front());
      end
      @(posedge clk);
      #1;
      exp_words = (ev_q.size() > 0) ? ev_cnt[ev_q[0]] : 0;
      if (rd_known) check("rd_data", rd_data, exp_rd);
      check("ready", 128'(rd_EvTID_ready), 128'(ev_q.size() > 0));
      check("words", 128'(rd_words), 128'(exp_words));
      check("ovf", 128'(ovf_err), 128'(exp_ovf));
      check("urun", 128'(urun_err), 128'(exp_urun));
   endtask

   task automatic do_rst();              step(1, 0, 0, '0, 0, 0, 0, 0); endtask
   task automatic idle();                step(0, 0, 0, '0, 0, 0, 0, 0); endtask
   task automatic wr(input int a, input logic [127:0] d); step(0, 1, a, d, 0, 0, 0, 0); endtask
   task automatic wdone();               step(0, 0, 0, '0, 1, 0, 0, 0); endtask
   task automatic rd(input int a);       step(0, 0, 0, '0, 0, 1, a, 0); endtask
   task automatic rdone();               step(0, 0, 0, '0, 0, 0, 0, 1); endtask

   logic [127:0] a0_val;

   initial begin
      cur_tag = "reset";
      do_rst();
      do_rst();
      check("rd_data_zero", rd_data, '0);
      check("ready_zero", 128'(rd_EvTID_ready), '0);

      cur_tag = "basic";
      for (int i = 0; i < 4; i++) wr(i, 128'(32'hA0 + i));
      wdone();
      check("words_is_4", 128'(rd_words), 128'd4);
      rd(2);
      check("rd_A2", rd_data, 128'hA2);
      rdone();

      cur_tag = "pingpong";
      do_rst();
      for (int i = 0; i < 8; i++) wr(i, rnd128());
      wdone();
      for (int i = 0; i < 5; i++) step(0, 1, i, rnd128(), 0, 1, 7 - i, 0);
      wdone();
      rd(3);
      rdone();
      check("words_is_5", 128'(rd_words), 128'd5);
      check("ready_stays", 128'(rd_EvTID_ready), 128'd1);
      rd(0);

      cur_tag = "overflow";
      do_rst();
      a0_val = rnd128();
      wr(0, a0_val);
      wr(1, rnd128());
      wr(2, rnd128());
      wdone();
      wr(0, rnd128());
      wr(1, rnd128());
      wdone();
      step(0, 1, 0, 128'hFF, 1, 0, 0, 0);
      check("ovf_set", 128'(ovf_err), 128'd1);
      rd(0);
      check("A0_kept", rd_data, a0_val);
      rdone();
      check("ready_B", 128'(rd_EvTID_ready), 128'd1);
      check("words_B", 128'(rd_words), 128'd2);
      rd(1);
      rdone();

      cur_tag = "underrun";
      rd(3);
      check("rd_zero", rd_data, '0);
      check("urun_set", 128'(urun_err), 128'd1);
      idle();
      idle();
      rdone();
      check("urun_sticky", 128'(urun_err), 128'd1);

      cur_tag = "coincident";
      do_rst();
      for (int i = 0; i < 4; i++) wr(i, rnd128());
      wdone();
      for (int i = 0; i < 6; i++) wr(i, rnd128());
      step(0, 0, 0, '0, 1, 0, 0, 1);
      check("words_is_6", 128'(rd_words), 128'd6);
      rd(5);
      rdone();
      step(0, 1, 9, rnd128(), 1, 0, 0, 0);
      check("words_is_10", 128'(rd_words), 128'd10);
      rd(9);
      rdone();

      cur_tag = "midreset";
      do_rst();
      rd(1);
      wr(0, rnd128());
      wr(1, rnd128());
      wdone();
      rdone();
      wr(0, rnd128());
      wdone();
      wr(0, rnd128());
      wr(2, rnd128());
      do_rst();
      check("ready_0", 128'(rd_EvTID_ready), '0);
      check("urun_0", 128'(urun_err), '0);
      wr(0, 128'h1234_5678_9ABC_DEF0);
      wdone();
      rd(0);
      check("single_word", rd_data, 128'h1234_5678_9ABC_DEF0);
      rdone();

      cur_tag = "random";
      do_rst();
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 200) == 0, $urandom % 2, $urandom_range(0, 15), rnd128(),
              ($urandom % 8) == 0, ($urandom % 3) == 0, $urandom_range(0, 15),
              ($urandom % 6) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
